// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - seven-segment pattern constants shared by display driver and monitor
// Purpose: abcdefg (bit 6 = a, bit 0 = g) active-high segment patterns for hex digits 0..F.
// Ports: none (package).
package sevenseg_pkg;

    typedef logic [6:0] seg_code_t;

    localparam seg_code_t SEG_BLANK = 7'h00;
    localparam seg_code_t SEG_HEX_0 = 7'h7E;
    localparam seg_code_t SEG_HEX_1 = 7'h30;
    localparam seg_code_t SEG_HEX_2 = 7'h6D;
    localparam seg_code_t SEG_HEX_3 = 7'h79;
    localparam seg_code_t SEG_HEX_4 = 7'h33;
    localparam seg_code_t SEG_HEX_5 = 7'h5B;
    localparam seg_code_t SEG_HEX_6 = 7'h5F;
    localparam seg_code_t SEG_HEX_7 = 7'h70;
    localparam seg_code_t SEG_HEX_8 = 7'h7F;
    localparam seg_code_t SEG_HEX_9 = 7'h7B;
    localparam seg_code_t SEG_HEX_A = 7'h77;
    localparam seg_code_t SEG_HEX_B = 7'h1F;
    localparam seg_code_t SEG_HEX_C = 7'h4E;
    localparam seg_code_t SEG_HEX_D = 7'h3D;
    localparam seg_code_t SEG_HEX_E = 7'h4F;
    localparam seg_code_t SEG_HEX_F = 7'h47;

endpackage

// File: rtl/seg_to_hex.sv
// rtl/seg_to_hex.sv - combinational seven-segment pattern to hex decoder
// Purpose: map an abcdefg pattern back to its hex value; flag patterns that are not a hex digit.
// Ports:
//   i_seg   - segment pattern {a,b,c,d,e,f,g}, active-high
//   o_hex   - decoded hex value (0 when illegal)
//   o_legal - 1 when i_seg is one of the 16 hex patterns (blank is illegal)
module seg_to_hex
    import sevenseg_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_hex,
    output logic       o_legal
);

    always_comb begin
        o_hex   = 4'h0;
        o_legal = 1'b1;
        case (seg_code_t'(i_seg))
            SEG_HEX_0: o_hex = 4'h0;
            SEG_HEX_1: o_hex = 4'h1;
            SEG_HEX_2: o_hex = 4'h2;
            SEG_HEX_3: o_hex = 4'h3;
            SEG_HEX_4: o_hex = 4'h4;
            SEG_HEX_5: o_hex = 4'h5;
            SEG_HEX_6: o_hex = 4'h6;
            SEG_HEX_7: o_hex = 4'h7;
            SEG_HEX_8: o_hex = 4'h8;
            SEG_HEX_9: o_hex = 4'h9;
            SEG_HEX_A: o_hex = 4'hA;
            SEG_HEX_B: o_hex = 4'hB;
            SEG_HEX_C: o_hex = 4'hC;
            SEG_HEX_D: o_hex = 4'hD;
            SEG_HEX_E: o_hex = 4'hE;
            SEG_HEX_F: o_hex = 4'hF;
            default:   o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/sevenseg_monitor.sv
// rtl/sevenseg_monitor.sv - receive side of the multiplexed seven-segment display bus
// Purpose: debounce each digit position's pattern, decode it, and publish complete frames.
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   seg_in       - segment lines {a,b,c,d,e,f,g}, active-high
//   dot_in       - decimal point line
//   dig_sel      - one-hot digit select, bit i = position i
//   value        - last complete frame, nibble i = position i
//   dots         - dot state per position for the last complete frame
//   valid        - at least one complete frame captured since reset
//   frame_done   - one-cycle pulse when value/dots update
//   bad_pattern  - one-cycle pulse after an accepted sample with an illegal code
module sevenseg_monitor
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int STABLE_CNT = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_in,
    input  logic                    dot_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   dots,
    output logic                    valid,
    output logic                    frame_done,
    output logic                    bad_pattern
);

    localparam int          TW     = NUM_DIGITS + 8;
    localparam logic [3:0]  STABLE = 4'(STABLE_CNT);

    logic [TW-1:0]           r_prev;
    logic [3:0]              r_cnt;
    logic [NUM_DIGITS-1:0]   r_mask;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [NUM_DIGITS-1:0]   r_shadow_dots;

    logic [TW-1:0]           w_tuple;
    logic                    w_onehot;
    logic                    w_changed;
    logic [3:0]              w_cnt_next;
    logic                    w_accept;
    logic                    w_full;
    logic [NUM_DIGITS-1:0]   w_mask_next;
    seg_code_t               w_seg;
    logic [3:0]              w_hex;
    logic                    w_legal;

    assign w_seg = seg_code_t'(seg_in);

    seg_to_hex u_seg_to_hex (
        .i_seg   (w_seg),
        .o_hex   (w_hex),
        .o_legal (w_legal)
    );

    assign w_tuple   = {dig_sel, seg_in, dot_in};
    assign w_onehot  = (dig_sel != '0) && ((dig_sel & (dig_sel - 1'b1)) == '0);
    assign w_changed = (w_tuple != r_prev);
    assign w_full    = &r_mask;

    always_comb begin
        w_cnt_next = 4'd0;
        if (w_onehot) begin
            if (w_changed)
                w_cnt_next = 4'd1;
            else if (r_cnt >= STABLE)
                w_cnt_next = STABLE;
            else
                w_cnt_next = r_cnt + 4'd1;
        end
    end

    // One accept per stable run. The w_changed term only matters when
    // STABLE_CNT is 1: the count sits at 1 and a fresh tuple must still accept.
    assign w_accept = w_onehot && (w_cnt_next == STABLE) && ((r_cnt != STABLE) || w_changed);

    // A completed frame clears the mask, but an accept on the same edge
    // re-seeds it so that sample counts toward the next frame.
    always_comb begin
        w_mask_next = w_full ? '0 : r_mask;
        if (w_accept) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (dig_sel[i])
                    w_mask_next[i] = w_legal;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev        <= '0;
            r_cnt         <= 4'd0;
            r_mask        <= '0;
            r_shadow      <= '0;
            r_shadow_dots <= '0;
            value         <= '0;
            dots          <= '0;
            valid         <= 1'b0;
            frame_done    <= 1'b0;
            bad_pattern   <= 1'b0;
        end else begin
            r_prev      <= w_tuple;
            r_cnt       <= w_cnt_next;
            r_mask      <= w_mask_next;
            frame_done  <= w_full;
            bad_pattern <= w_accept && !w_legal;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_accept && w_legal && dig_sel[i]) begin
                    r_shadow[4*i +: 4] <= w_hex;
                    r_shadow_dots[i]   <= dot_in;
                end
            end
            if (w_full) begin
                value <= r_shadow;
                dots  <= r_shadow_dots;
                valid <= 1'b1;
            end
        end
    end

endmodule
